// File: rtl/output_frame_packer_pkg.sv
// Shared types and frame-geometry helpers for output_frame_packer.
// FRAME_CHECKSUM_EN adds a trailing XOR checksum word to each frame.
package frame_pkg;

   typedef enum logic {IDLE, SEND} frame_state_t;

   function automatic int frame_len(input int num_ch);
`ifdef FRAME_CHECKSUM_EN
      return num_ch + 2;
`else
      return num_ch + 1;
`endif
   endfunction

   function automatic int idx_w(input int num_ch);
      return $clog2(num_ch + 2);
   endfunction

endpackage

// File: rtl/output_frame_packer_if.sv
// Valid/ready stream bundle from the frame packer toward the DMA/host link.
interface output_frame_packer_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;
   logic              last;

   modport master (output data, valid, last, input ready);
   modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/output_frame_packer_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_ni,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_o <= '0;
      end else if (inc_i && !(&cnt_o)) begin
         cnt_o <= cnt_o + W'(1);
      end
   end

endmodule

// File: rtl/output_frame_packer.sv
// Snapshots NUM_CH channels and streams header, channels (and optional
// checksum when FRAME_CHECKSUM_EN is defined) as one valid/ready burst.
module output_frame_packer
   import frame_pkg::*;
#(
   parameter int NUM_CH = 8,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst_ni,
   input  logic [NUM_CH*DATA_W-1:0] ch_i,
   input  logic                     sample_valid_i,
   output_frame_packer_if.master    m,
   output logic                     busy_o,
   output logic [CNT_W-1:0]         frame_cnt_o,
   output logic [CNT_W-1:0]         drop_cnt_o
);

   localparam int IDX_W = idx_w(NUM_CH);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(frame_len(NUM_CH) - 1);

   frame_state_t      state_q, state_d;
   logic [IDX_W-1:0]  idx_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] sh_q [NUM_CH];
   logic [DATA_W-1:0] nxt_word;
   logic [DATA_W-1:0] hdr;
   logic              hs, at_last, fin;
   logic              accept, drop, advance;

   assign hdr = DATA_W'(frame_cnt_o);

`ifdef FRAME_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q;
   logic [DATA_W-1:0] csum_d;

   always_comb begin
      csum_d = hdr;
      for (int k = 0; k < NUM_CH; k++) begin
         csum_d = csum_d ^ ch_i[k*DATA_W +: DATA_W];
      end
   end
`endif

   always_comb begin
      hs      = m.valid & m.ready;
      at_last = (idx_q == LAST);
      fin     = (state_q == SEND) && hs && at_last;
      accept  = sample_valid_i && ((state_q == IDLE) || fin);
      drop    = sample_valid_i && (state_q == SEND) && !fin;
      advance = hs && !at_last;
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = SEND;
         SEND: if (fin && !accept) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Word following idx_q: channel idx_q, or the checksum after the last channel.
   always_comb begin
`ifdef FRAME_CHECKSUM_EN
      nxt_word = csum_q;
`else
      nxt_word = '0;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
         if (idx_q == IDX_W'(k)) nxt_word = sh_q[k];
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         data_q      <= '0;
         frame_cnt_o <= '0;
         for (int k = 0; k < NUM_CH; k++) sh_q[k] <= '0;
`ifdef FRAME_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            for (int k = 0; k < NUM_CH; k++) begin
               sh_q[k] <= ch_i[k*DATA_W +: DATA_W];
            end
`ifdef FRAME_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
            data_q      <= hdr;
            idx_q       <= '0;
            frame_cnt_o <= frame_cnt_o + CNT_W'(1);
         end else if (advance) begin
            idx_q  <= idx_q + IDX_W'(1);
            data_q <= nxt_word;
         end
      end
   end

   assign m.valid = (state_q == SEND);
   assign m.last  = m.valid && at_last;
   assign m.data  = data_q;
   assign busy_o  = m.valid;

   sat_counter #(.W(CNT_W)) u_drop (
      .clk    (clk),
      .rst_ni (rst_ni),
      .inc_i  (drop),
      .cnt_o  (drop_cnt_o)
   );

endmodule
